// File: rtl/cnnip_cmd_regs.sv
// Host register block and run sequencer for the CNN IP.
// Define CNNIP_IRQ_EN to add the irq port and the IRQ_EN register at 0x14.
module cnnip_cmd_regs #(
    parameter int CYC_W = 32
) (
    input  logic        clk_a,
    input  logic        arstz_aq,
    input  logic        reg_req,
    input  logic        reg_we,
    input  logic [7:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_ack,
    output logic        CMD_START,
    output logic [7:0]  MODE_KERNEL_SIZE,
    output logic [7:0]  MODE_KERNEL_NUMS,
    output logic [1:0]  MODE_STRIDE,
    output logic        MODE_PADDING,
    input  logic        CMD_DONE,
    input  logic        CMD_DONE_VALID
`ifdef CNNIP_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] A_CTRL = 8'h00;
    localparam logic [7:0] A_MODE = 8'h04;
    localparam logic [7:0] A_STAT = 8'h08;
    localparam logic [7:0] A_DCNT = 8'h0C;
    localparam logic [7:0] A_CYC  = 8'h10;
`ifdef CNNIP_IRQ_EN
    localparam logic [7:0] A_IRQE = 8'h14;
`endif

    state_t           state;
    logic [18:0]      mode_q;
    logic             done_q;
    logic             err_q;
    logic [15:0]      dcnt_q;
    logic [CYC_W-1:0] run_cnt;
    logic [CYC_W-1:0] cyc_q;

    logic        acc;
    logic        wr;
    logic        rd;
    logic        busy;
    logic        done_ev;
    logic        start_wr;
    logic        mode_wr;
    logic        stat_wr;
    logic        err_set;
    logic        done_d;
    logic        err_d;
    logic [31:0] rd_mux;
    logic        wdata_unused;

    // A request landing on the ack cycle is dropped, never queued
    assign acc      = reg_req && !reg_ack;
    assign wr       = acc && reg_we;
    assign rd       = acc && !reg_we;
    assign busy     = (state == RUN);
    assign done_ev  = busy && CMD_DONE_VALID && CMD_DONE;
    assign start_wr = wr && (reg_addr == A_CTRL) && reg_wdata[0];
    assign mode_wr  = wr && (reg_addr == A_MODE);
    assign stat_wr  = wr && (reg_addr == A_STAT);
    assign err_set  = busy && (start_wr || mode_wr);

    // Set terms are ORed in after the W1C mask so a same-cycle set wins
    assign done_d = done_ev || (done_q && !(stat_wr && reg_wdata[1]));
    assign err_d  = err_set || (err_q && !(stat_wr && reg_wdata[2]));

    assign wdata_unused = ^reg_wdata[31:19];

    assign MODE_KERNEL_SIZE = mode_q[7:0];
    assign MODE_KERNEL_NUMS = mode_q[15:8];
    assign MODE_STRIDE      = mode_q[17:16];
    assign MODE_PADDING     = mode_q[18];

`ifdef CNNIP_IRQ_EN
    logic irq_en_q;
    logic irq_en_d;

    assign irq_en_d = (wr && (reg_addr == A_IRQE)) ? reg_wdata[0] : irq_en_q;

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            irq_en_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq      <= irq_en_d && (done_d || err_d);
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            A_MODE: rd_mux = {13'h0, mode_q};
            A_STAT: rd_mux = {29'h0, err_q, done_q, busy};
            A_DCNT: rd_mux = {16'h0, dcnt_q};
            A_CYC:  rd_mux = 32'(cyc_q);
`ifdef CNNIP_IRQ_EN
            A_IRQE: rd_mux = {31'h0, irq_en_q};
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            state     <= IDLE;
            CMD_START <= 1'b0;
            run_cnt   <= '0;
            cyc_q     <= '0;
            dcnt_q    <= '0;
        end else begin
            CMD_START <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_wr) begin
                        state     <= RUN;
                        CMD_START <= 1'b1;
                        run_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (run_cnt != '1)
                        run_cnt <= run_cnt + CYC_W'(1);
                    if (done_ev) begin
                        state  <= IDLE;
                        cyc_q  <= run_cnt;
                        dcnt_q <= dcnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            reg_ack   <= 1'b0;
            reg_rdata <= '0;
            mode_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            reg_ack   <= acc;
            reg_rdata <= rd ? rd_mux : '0;
            if (mode_wr && !busy)
                mode_q <= reg_wdata[18:0];
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_cnnip_cmd_regs.sv
// Randomized and directed bench for cnnip_cmd_regs against a
// transaction-level model of the register map and run bookkeeping.
module tb_cnnip_cmd_regs;

    localparam int CW     = 8;
    localparam int CYCMAX = (1 << CW) - 1;

    logic        clk_a = 1'b0;
    logic        arstz_aq = 1'b1;
    logic        reg_req = 1'b0;
    logic        reg_we = 1'b0;
    logic [7:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        CMD_START;
    logic [7:0]  MODE_KERNEL_SIZE;
    logic [7:0]  MODE_KERNEL_NUMS;
    logic [1:0]  MODE_STRIDE;
    logic        MODE_PADDING;
    logic        CMD_DONE = 1'b0;
    logic        CMD_DONE_VALID = 1'b0;
`ifdef CNNIP_IRQ_EN
    logic        irq;
`endif

    always #5 clk_a = ~clk_a;

    cnnip_cmd_regs #(.CYC_W(CW)) dut (
        .clk_a            (clk_a),
        .arstz_aq         (arstz_aq),
        .reg_req          (reg_req),
        .reg_we           (reg_we),
        .reg_addr         (reg_addr),
        .reg_wdata        (reg_wdata),
        .reg_rdata        (reg_rdata),
        .reg_ack          (reg_ack),
        .CMD_START        (CMD_START),
        .MODE_KERNEL_SIZE (MODE_KERNEL_SIZE),
        .MODE_KERNEL_NUMS (MODE_KERNEL_NUMS),
        .MODE_STRIDE      (MODE_STRIDE),
        .MODE_PADDING     (MODE_PADDING),
        .CMD_DONE         (CMD_DONE),
        .CMD_DONE_VALID   (CMD_DONE_VALID)
`ifdef CNNIP_IRQ_EN
        ,
        .irq              (irq)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model state: what the host should observe through the map
    bit          m_busy, m_done, m_err, m_irq_en, m_ack;
    logic [18:0] m_mode;
    int          m_dcnt, m_cyc, m_edge, m_start_edge;
    logic [31:0] last_rd;
    int          pulse_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [7:0] a);
        case (a)
            8'h04: return {13'h0, m_mode};
            8'h08: return {29'h0, m_err, m_done, m_busy};
            8'h0C: return 32'(m_dcnt);
            8'h10: return 32'(m_cyc);
`ifdef CNNIP_IRQ_EN
            8'h14: return {31'h0, m_irq_en};
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] obs_mode();
        return {13'h0, MODE_PADDING, MODE_STRIDE,
                MODE_KERNEL_NUMS, MODE_KERNEL_SIZE};
    endfunction

    // One clock edge: drive, predict, then check after the edge
    task automatic step(input bit req, input bit we, input logic [7:0] a,
                        input logic [31:0] d, input bit dv, input bit dn);
        bit          acc, cmpl, st, es, e_rd;
        logic [31:0] e_rdata;
        int          run;
        @(negedge clk_a);
        reg_req = req;
        reg_we = we;
        reg_addr = a;
        reg_wdata = d;
        CMD_DONE_VALID = dv;
        CMD_DONE = dn;
        m_edge++;
        acc = req && !m_ack;
        cmpl = m_busy && dv && dn;
        e_rd = acc && !we;
        e_rdata = e_rd ? mread(a) : 32'h0;
        st = 1'b0;
        es = 1'b0;
        if (acc && we) begin
            if (a == 8'h00 && d[0]) begin
                if (m_busy) es = 1'b1;
                else st = 1'b1;
            end
            if (a == 8'h04) begin
                if (m_busy) es = 1'b1;
                else m_mode = d[18:0];
            end
            if (a == 8'h08) begin
                if (d[1]) m_done = 1'b0;
                if (d[2]) m_err = 1'b0;
            end
`ifdef CNNIP_IRQ_EN
            if (a == 8'h14) m_irq_en = d[0];
`endif
        end
        if (es) m_err = 1'b1;
        if (cmpl) begin
            m_done = 1'b1;
            m_busy = 1'b0;
            m_dcnt = (m_dcnt + 1) % 65536;
            // full RUN cycles before the cycle where completion is sampled
            run = m_edge - m_start_edge - 1;
            m_cyc = (run > CYCMAX) ? CYCMAX : run;
        end
        if (st) begin
            m_busy = 1'b1;
            m_start_edge = m_edge;
        end
        m_ack = acc;
        @(posedge clk_a);
        #1;
        if (CMD_START) pulse_cnt++;
        chk("ack", {31'h0, reg_ack}, {31'h0, m_ack});
        if (e_rd) begin
            chk($sformatf("rd_%02h", a), reg_rdata, e_rdata);
            last_rd = reg_rdata;
        end
        chk("start", {31'h0, CMD_START}, {31'h0, st});
        chk("mode", obs_mode(), {13'h0, m_mode});
`ifdef CNNIP_IRQ_EN
        chk("irq", {31'h0, irq}, {31'h0, m_irq_en && (m_done || m_err)});
`endif
    endtask

    task automatic idle(input int n, input bit rnd_done);
        bit dv;
        for (int i = 0; i < n; i++) begin
            dv = rnd_done ? 1'($urandom_range(0, 1)) : 1'b0;
            step(1'b0, 1'b0, 8'h00, 32'h0, dv,
                 rnd_done && !m_busy && dv);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, a, d, 1'b0, 1'b0);
        idle(1, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b1, 1'b0, a, 32'h0, 1'b0, 1'b0);
        idle(1, 1'b0);
    endtask

    task automatic finish_run();
        step(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1);
        idle(1, 1'b0);
    endtask

    task automatic do_reset();
        reg_req = 1'b0;
        CMD_DONE_VALID = 1'b0;
        CMD_DONE = 1'b0;
        arstz_aq = 1'b0;
        #1;
        chk("rst_ack", {31'h0, reg_ack}, 32'h0);
        chk("rst_rdata", reg_rdata, 32'h0);
        chk("rst_start", {31'h0, CMD_START}, 32'h0);
        chk("rst_mode", obs_mode(), 32'h0);
`ifdef CNNIP_IRQ_EN
        chk("rst_irq", {31'h0, irq}, 32'h0);
`endif
        repeat (2) @(negedge clk_a);
        arstz_aq = 1'b1;
        m_busy = 0; m_done = 0; m_err = 0; m_irq_en = 0; m_ack = 0;
        m_mode = '0; m_dcnt = 0; m_cyc = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          p0;
        logic [7:0]  addrs [8];
        logic [7:0]  a;
        bit          req, we, dv, dn;
        m_edge = 0;
        m_start_edge = 0;
        #1;
        do_reset();

        rd(8'h08);
        chk("rst_status", last_rd, 32'h0);
        rd(8'h0C);
        chk("rst_dcnt", last_rd, 32'h0);
        rd(8'h10);
        chk("rst_cyc", last_rd, 32'h0);

        wr(8'h04, 32'h0001_0305);
        chk("mode_size", {24'h0, MODE_KERNEL_SIZE}, 32'd5);
        chk("mode_nums", {24'h0, MODE_KERNEL_NUMS}, 32'd3);
        chk("mode_stride", {30'h0, MODE_STRIDE}, 32'd1);
        chk("mode_pad", {31'h0, MODE_PADDING}, 32'd0);

        step(1'b1, 1'b1, 8'h00, 32'h1, 1'b0, 1'b0);
        chk("pulse_hi", {31'h0, CMD_START}, 32'h1);
        idle(1, 1'b0);
        chk("pulse_lo", {31'h0, CMD_START}, 32'h0);
        idle(98, 1'b1);
        finish_run();
        rd(8'h08);
        chk("status_done", last_rd, 32'h2);
        rd(8'h0C);
        chk("dcnt_1", last_rd, 32'd1);
        rd(8'h10);
        chk("cyc_100", last_rd, 32'd99);

        wr(8'h08, 32'h2);
        wr(8'h00, 32'h1);
        p0 = pulse_cnt;
        wr(8'h00, 32'h1);
        wr(8'h04, 32'h0002_0A07);
        chk("busy_nopulse", 32'(pulse_cnt - p0), 32'h0);
        chk("busy_mode", obs_mode(), 32'h0001_0305);
        rd(8'h08);
        chk("busy_err", last_rd, 32'h5);
        wr(8'h08, 32'h4);
        rd(8'h08);
        chk("err_w1c", last_rd, 32'h1);
        step(1'b1, 1'b1, 8'h08, 32'h2, 1'b1, 1'b1);
        idle(1, 1'b0);
        rd(8'h08);
        chk("done_set_wins", last_rd, 32'h2);

        wr(8'h00, 32'h1);
        idle(3, 1'b0);
        p0 = pulse_cnt;
        step(1'b1, 1'b1, 8'h00, 32'h1, 1'b1, 1'b1);
        idle(1, 1'b0);
        chk("start_on_done", 32'(pulse_cnt - p0), 32'h0);
        rd(8'h08);
        chk("start_on_done_st", last_rd, 32'h6);
        wr(8'h08, 32'h6);

        step(1'b1, 1'b0, 8'h08, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h0C, 32'h0, 1'b0, 1'b0);
        chk("b2b_ignored", {31'h0, reg_ack}, 32'h0);
        idle(1, 1'b0);

        rd(8'h18);
        chk("unmapped_rd", last_rd, 32'h0);
        rd(8'h05);
        chk("misaligned_rd", last_rd, 32'h0);
        wr(8'h18, 32'hFFFF_FFFF);
        rd(8'h04);
        chk("unmapped_wr", last_rd, 32'h0001_0305);

`ifdef CNNIP_IRQ_EN
        wr(8'h14, 32'h1);
        wr(8'h00, 32'h1);
        idle(5, 1'b0);
        step(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1);
        chk("irq_set", {31'h0, irq}, 32'h1);
        idle(1, 1'b0);
        step(1'b1, 1'b1, 8'h08, 32'h2, 1'b0, 1'b0);
        chk("irq_clr", {31'h0, irq}, 32'h0);
        idle(1, 1'b0);
        wr(8'h14, 32'h0);
`else
        rd(8'h14);
        chk("no_irq_reg", last_rd, 32'h0);
`endif

        wr(8'h00, 32'h1);
        idle(300, 1'b0);
        finish_run();
        rd(8'h10);
        chk("cyc_sat", last_rd, 32'(CYCMAX));
        wr(8'h08, 32'h6);

        step(1'b1, 1'b1, 8'h00, 32'h1, 1'b0, 1'b0);
        do_reset();
        rd(8'h08);
        chk("midrun_status", last_rd, 32'h0);
        rd(8'h0C);
        chk("midrun_dcnt", last_rd, 32'h0);
        wr(8'h00, 32'h1);
        idle(10, 1'b1);
        finish_run();
        rd(8'h0C);
        chk("rerun_dcnt", last_rd, 32'd1);
        rd(8'h08);
        chk("rerun_status", last_rd, 32'h2);

        addrs[0] = 8'h00; addrs[1] = 8'h04; addrs[2] = 8'h08;
        addrs[3] = 8'h0C; addrs[4] = 8'h10; addrs[5] = 8'h14;
        addrs[6] = 8'h18; addrs[7] = 8'h00;
        for (int i = 0; i < 800; i++) begin
            a = addrs[$urandom_range(0, 7)];
            if ($urandom_range(0, 15) == 0) a = 8'($urandom);
            req = ($urandom_range(0, 9) < 5);
            we = 1'($urandom_range(0, 1));
            dv = 1'($urandom_range(0, 1));
            dn = ($urandom_range(0, 15) == 0);
            step(req, we, a, $urandom, dv, dn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cnnip_cmd_regs.md
CNNIP_CMD_REGS -- requirements
Module: cnnip_cmd_regs

Interface
REQ-001 SHALL have parameter: CYC_W, default 32, width of the run-cycle counter.
REQ-002 SHALL have port: clk_a  input  1  clock; all logic is clocked on the rising edge.
REQ-003 SHALL have port: arstz_aq  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: reg_req  input  1  host register access request, one-cycle strobe.
REQ-005 SHALL have port: reg_we  input  1  1 = write, 0 = read; qualified by reg_req.
REQ-006 SHALL have port: reg_addr  input  8  byte address, word aligned.
REQ-007 SHALL have port: reg_wdata  input  32  write data.
REQ-008 SHALL have port: reg_rdata  output  32  read data; valid only while reg_ack is high.
REQ-009 SHALL have port: reg_ack  output  1  access-complete strobe.
REQ-010 SHALL have port: CMD_START  output  1  one-cycle start pulse to the CNN controller.
REQ-011 SHALL have ports: MODE_KERNEL_SIZE, MODE_KERNEL_NUMS, MODE_STRIDE, MODE_PADDING  output  8/8/2/1  layer configuration.
REQ-012 SHALL have ports: CMD_DONE, CMD_DONE_VALID  input  1/1  completion report from the CNN controller.
REQ-013 SHALL have port: irq  output  1  interrupt; exists only under CNNIP_IRQ_EN.

Function
REQ-014 SHALL implement this register map:
- 0x00 CTRL: bit0 START, write-1 pulse, reads 0.
- 0x04 MODE: [7:0] size, [15:8] nums, [17:16] stride, [18] padding.
- 0x08 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, W1C), bit2 ERR (sticky, W1C).
- 0x0C DONE_CNT: 16-bit completed-run count (RO).
- 0x10 CYC: cycle count of the last completed run (RO).
- 0x14 IRQ_EN: bit0; present only under the macro.
REQ-015 SHALL raise reg_ack exactly 1 cycle after an accepted reg_req; reg_rdata SHALL be registered and presented with the ack.
REQ-016 SHALL ack reads to unmapped addresses with data 0, and SHALL ack and discard writes to unmapped addresses.
REQ-017 SHALL ignore a reg_req asserted in the same cycle that reg_ack is high (no back-to-back accesses).
REQ-018 SHALL implement an FSM with two states, IDLE and RUN; BUSY SHALL equal (state == RUN).
REQ-019 IDLE -> RUN: a write to CTRL with bit0 = 1 SHALL assert CMD_START high for exactly the next cycle and enter RUN on that same cycle.
REQ-020 RUN -> IDLE: on any cycle with CMD_DONE_VALID && CMD_DONE, the block SHALL:
- set DONE;
- increment DONE_CNT, wrapping 0xFFFF -> 0;
- load CYC with the run counter.
REQ-021 In RUN, CMD_DONE_VALID without CMD_DONE SHALL be ignored; done inputs in IDLE SHALL be ignored.
REQ-022 The run counter SHALL clear to 0 on entry to RUN, increment by 1 each RUN cycle, and saturate at all ones.
REQ-023 A START write or a MODE write while BUSY SHALL be dropped (no pulse, MODE unchanged) and SHALL set ERR.
REQ-024 MODE outputs SHALL be driven directly from the MODE register, so they are stable throughout RUN.
REQ-025 If a DONE or ERR set event and a W1C clear of the same bit occur in the same cycle, the set SHALL win.
REQ-026 A START write that coincides with a completion SHALL be treated as issued while BUSY (see REQ-023).

Reset
REQ-027 On arstz_aq low, the block SHALL immediately force:
- state IDLE;
- all registers and counters to 0;
- reg_ack, reg_rdata, CMD_START and irq to 0.
REQ-028 A reset asserted mid-run SHALL abandon the run without updating DONE, DONE_CNT or CYC.

Configuration
REQ-029 With CNNIP_IRQ_EN defined:
- the irq port and the IRQ_EN register SHALL exist;
- irq SHALL be registered and equal IRQ_EN & (DONE | ERR).
REQ-030 Without CNNIP_IRQ_EN: the irq port SHALL not exist, and 0x14 SHALL behave as unmapped.

Verification
REQ-031 Write MODE=0x0001_0305, then START -> CMD_START pulses 1 cycle; outputs size=5, nums=3, stride=1, padding=0.
REQ-032 START, then 100 cycles later assert CMD_DONE_VALID & CMD_DONE -> BUSY drops; STATUS reads 0x2; DONE_CNT=1; CYC=100 (±1 per the defined counting edge, fixed in the testbench).
REQ-033 Write START and MODE while BUSY -> no second CMD_START; MODE unchanged; STATUS bit2 = 1; W1C 0x4 then clears ERR.
REQ-034 W1C of DONE in the same cycle as a new completion -> DONE remains 1.
REQ-035 Pull arstz_aq low during RUN -> CMD_START = 0, STATUS = 0, DONE_CNT = 0; a subsequent run works normally.
REQ-036 With CNNIP_IRQ_EN: IRQ_EN=1, complete a run -> irq = 1; W1C DONE -> irq = 0 on the next cycle. Without the macro: read 0x14 -> 0.
